mem_responder: RTL and testbench
================================

# mem_responder

Byte-array memory target that answers the execute stage's memory request interface. It accepts one load or store at a time and serializes 8/16/32-bit accesses into single-byte array operations, one byte per cycle, little-endian. It returns read data and a one-cycle `mem_ready` pulse. It sits between the execute stage's memory port and the on-chip data RAM.

## Interface
- `M_WIDTH`, 32: data/address bus width; must be ≥ 32.
- `ADDR_BITS`, 8: array is 2^ADDR_BITS bytes; `mem_addr` bits above this are ignored.
- `MEM_ACC_8`, 2'b00: byte access code.
- `MEM_ACC_16`, 2'b01: halfword access code.
- `MEM_ACC_32`, 2'b10: word access code.

Ports:
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst_n`  in  1  reset; one clock, synchronous, active-low.
- `mem_req`  in  1  request. The initiator holds it, with all request fields, stable until it samples `mem_ready`.
- `mem_we`  in  1  1 = store, 0 = load.
- `mem_addr`  in  M_WIDTH  byte address of the lowest byte.
- `mem_wdata`  in  M_WIDTH  store data; byte k goes to address `mem_addr+k`.
- `mem_acc_width`  in  2  access size code.
- `mem_rdata`  out  M_WIDTH  load result, zero-extended, registered.
- `mem_ready`  out  1  completion pulse, registered, exactly 1 cycle.
- `mem_fault`  out  1  misaligned-access flag, valid with `mem_ready` (see Configuration).

## Operation
- FSM states: IDLE, BUSY, DONE, RELEASE.
- **IDLE**
  - On `mem_req`=1: latch `addr[ADDR_BITS-1:0]`, `we`, `wdata`, and byte count N (1/2/4 for 00/01/10).
  - Clear byte index and read accumulator; go to BUSY.
  - Code 2'b11 is reserved: N=0, no array access, go directly to DONE with `mem_rdata`←0.
- **BUSY**, one byte per cycle, for index i = 0..N-1:
  - Array address is `(addr+i) mod 2^ADDR_BITS`; it wraps at the top of the array.
  - Store: `array[addr+i] ← wdata[8i+7:8i]`.
  - Load: `acc[8i+7:8i] ← array[addr+i]`.
  - After byte N-1, go to DONE.
- **DONE**
  - `mem_ready`=1 for this cycle only.
  - For a load, `mem_rdata` = acc with bits above 8N zero; it was loaded on the edge entering DONE.
  - Stores leave `mem_rdata` unchanged.
  - Next state is RELEASE unconditionally.
- **RELEASE**
  - Wait until `mem_req`=0, then go to IDLE.
  - A request held high past `mem_ready` is never serviced twice.
- `mem_rdata` holds its value until the next load completes; the initiator reads it after `mem_ready`.
- No sign extension: loads return raw bytes, and the initiator owns extension.
- Request fields are sampled only in IDLE; changes while BUSY are ignored.

## Timing
- Reset (`rst_n`=0 at an edge): state IDLE, `mem_ready`=0, `mem_rdata`=0, `mem_fault`=0, index 0. Array contents are not reset.
- Reset mid-BUSY: store bytes already written stay written; no `mem_ready` is issued.
- Latency, with request first sampled in cycle 0: BUSY in cycles 1..N, `mem_ready` in cycle N+1.
  - Byte: `mem_ready` in cycle 2.
  - Half: `mem_ready` in cycle 3.
  - Word: `mem_ready` in cycle 5.
  - Reserved code: `mem_ready` in cycle 1.
- Minimum spacing: a new request is accepted no earlier than the cycle after RELEASE samples `mem_req`=0. Back-to-back byte accesses take ≥4 cycles each.
- `mem_req` falling while BUSY or DONE is ignored; the access completes.

## Configuration
- Macro: `MEM_RESPONDER_ALIGN_CHECK_EN`.
- Defined:
  - Alignment is checked in IDLE. A half access needs `addr[0]`=0; a word access needs `addr[1:0]`=0.
  - Misaligned: no array access, go directly to DONE, `mem_ready`=1 and `mem_fault`=1 in cycle 1, `mem_rdata` unchanged.
  - `mem_fault` otherwise 0.
- Undefined:
  - Misaligned accesses proceed byte-serially with address wrap.
  - `mem_fault` is tied to 0.

## Test plan
- Word store `addr`=0x10, `wdata`=0xDEADBEEF, then word load 0x10 -> `mem_ready` in cycle 5 of each; `mem_rdata`=0xDEADBEEF; array[0x10..0x13]=EF,BE,AD,DE.
- Byte load 0x12 after the above -> `mem_rdata`=0x000000AD, `mem_ready` in cycle 2. Half load 0x12 -> 0x0000DEAD.
- Word store at 0xFE, `wdata`=0x44332211 (ADDR_BITS=8, macro undefined) -> array[0xFE]=11, [0xFF]=22, [0x00]=33, [0x01]=44. Same access with macro defined -> `mem_fault`=1 with `mem_ready` in cycle 1, array untouched.
- `mem_req` held high for 10 cycles on one byte load -> exactly one `mem_ready` pulse. Drop req, re-assert -> second pulse ≥4 cycles after the first.
- `rst_n` pulsed low in cycle 2 of a word store to 0x20 -> no `mem_ready`. Array[0x20] updated, [0x22..0x23] unchanged. Outputs 0 after reset.
- Reserved `mem_acc_width`=2'b11 load -> `mem_ready` in cycle 1, `mem_rdata`=0, no array change.

Source files
------------

// File: rtl/mem_responder.sv
// mem_responder: byte-serial little-endian memory target; MEM_RESPONDER_ALIGN_CHECK_EN faults misaligned half/word.
// Latency: N+1 cycles from request sample to the one-cycle mem_ready pulse (1 cycle for reserved/faulted).
// Backpressure: one access at a time; a held request is not re-served until mem_req drops.
module mem_responder #(
  parameter int         M_WIDTH    = 32,
  parameter int         ADDR_BITS  = 8,
  parameter logic [1:0] MEM_ACC_8  = 2'b00,
  parameter logic [1:0] MEM_ACC_16 = 2'b01,
  parameter logic [1:0] MEM_ACC_32 = 2'b10
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               mem_req,
  input  logic               mem_we,
  input  logic [M_WIDTH-1:0] mem_addr,
  input  logic [M_WIDTH-1:0] mem_wdata,
  input  logic [1:0]         mem_acc_width,
  output logic [M_WIDTH-1:0] mem_rdata,
  output logic               mem_ready,
  output logic               mem_fault
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE, RELEASE} state_t;
  state_t state, state_nxt;

  logic [7:0]           mem_arr [0:(1<<ADDR_BITS)-1];
  logic [ADDR_BITS-1:0] addr_q;
  logic [ADDR_BITS-1:0] cur_addr;
  logic                 we_q;
  logic [M_WIDTH-1:0]   wdata_q;
  logic [2:0]           cnt_q;
  logic [2:0]           idx_q;
  logic [2:0]           n_req;
  logic [31:0]          acc_q;
  logic [31:0]          acc_nxt;
  logic                 misalign;
  logic                 fault_entry;
  logic                 last_byte;
  logic                 unused_addr_hi;

  assign unused_addr_hi = ^mem_addr[M_WIDTH-1:ADDR_BITS];

  always_comb begin
    n_req = 3'd0;
    case (mem_acc_width)
      MEM_ACC_8:  n_req = 3'd1;
      MEM_ACC_16: n_req = 3'd2;
      MEM_ACC_32: n_req = 3'd4;
      default:    n_req = 3'd0;
    endcase
  end

`ifdef MEM_RESPONDER_ALIGN_CHECK_EN
  assign misalign = ((mem_acc_width == MEM_ACC_16) && mem_addr[0]) ||
                    ((mem_acc_width == MEM_ACC_32) && (mem_addr[1:0] != 2'b00));
`else
  assign misalign = 1'b0;
`endif

  // Array address wraps naturally at the top through the ADDR_BITS-wide add.
  assign cur_addr  = addr_q + ADDR_BITS'(idx_q);
  assign last_byte = ((idx_q + 3'd1) == cnt_q);

  always_comb begin
    acc_nxt = acc_q;
    acc_nxt[{idx_q[1:0], 3'b000} +: 8] = mem_arr[cur_addr];
  end

  always_comb begin
    state_nxt   = state;
    fault_entry = 1'b0;
    case (state)
      IDLE: begin
        if (mem_req) begin
          if (misalign) begin
            state_nxt   = DONE;
            fault_entry = 1'b1;
          end else if (n_req == 3'd0) begin
            state_nxt = DONE;
          end else begin
            state_nxt = BUSY;
          end
        end
      end
      BUSY:    if (last_byte) state_nxt = DONE;
      DONE:    state_nxt = RELEASE;
      RELEASE: if (!mem_req) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      mem_ready <= 1'b0;
      mem_rdata <= '0;
      mem_fault <= 1'b0;
      idx_q     <= '0;
      acc_q     <= '0;
    end else begin
      state     <= state_nxt;
      mem_ready <= (state_nxt == DONE);
      mem_fault <= fault_entry;
      case (state)
        IDLE: begin
          if (mem_req) begin
            addr_q  <= mem_addr[ADDR_BITS-1:0];
            we_q    <= mem_we;
            wdata_q <= mem_wdata;
            cnt_q   <= n_req;
            idx_q   <= '0;
            acc_q   <= '0;
            if (!misalign && (n_req == 3'd0)) mem_rdata <= '0;
          end
        end
        BUSY: begin
          idx_q   <= idx_q + 3'd1;
          wdata_q <= wdata_q >> 8;
          if (!we_q) begin
            acc_q <= acc_nxt;
            if (last_byte) mem_rdata <= M_WIDTH'(acc_nxt);
          end
        end
        default: ;
      endcase
    end
  end

  // Array is never reset; a reset edge suppresses the write in flight.
  always_ff @(posedge clk) begin
    if (rst_n && (state == BUSY) && we_q) mem_arr[cur_addr] <= wdata_q[7:0];
  end

endmodule

// File: tb/tb_mem_responder.sv
// Randomized bench for mem_responder against a byte-array reference model.
module tb_mem_responder;

`ifdef MEM_RESPONDER_ALIGN_CHECK_EN
  localparam bit ALIGN = 1'b1;
`else
  localparam bit ALIGN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [1:0]  mem_acc_width;
  logic [31:0] mem_rdata;
  logic        mem_ready;
  logic        mem_fault;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int last_ready_cyc = 0;
  logic [7:0]  ref_mem [0:255];
  logic [31:0] last_rd = 32'h0;

  mem_responder dut (
    .clk(clk), .rst_n(rst_n), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_acc_width(mem_acc_width),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready), .mem_fault(mem_fault)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference: size, alignment and wrap rules applied to a plain byte array.
  function automatic void model(input logic we, input logic [31:0] a, input logic [31:0] wd,
                                input logic [1:0] w, output int lat, output logic [31:0] rd,
                                output logic f);
    int n;
    int idx;
    n = (w == 2'b00) ? 1 : (w == 2'b01) ? 2 : (w == 2'b10) ? 4 : 0;
    f = ALIGN && (((w == 2'b01) && a[0]) || ((w == 2'b10) && (a[1:0] != 2'b00)));
    if (f) begin
      lat = 1;
    end else if (n == 0) begin
      lat = 1;
      last_rd = 32'h0;
    end else begin
      lat = n + 1;
      if (!we) last_rd = 32'h0;
      for (int i = 0; i < n; i++) begin
        idx = (int'(a[7:0]) + i) % 256;
        if (we) ref_mem[idx] = 8'((wd >> (8 * i)) & 32'hFF);
        else    last_rd = last_rd | (32'(ref_mem[idx]) << (8 * i));
      end
    end
    rd = last_rd;
  endfunction

  // Starts and ends on a negedge with the DUT idle.
  task automatic access(input logic we, input logic [31:0] a, input logic [31:0] wd,
                        input logic [1:0] w, input bit scramble, input string tag);
    int lat;
    int k;
    logic [31:0] rd;
    logic f;
    bit seen;
    model(we, a, wd, w, lat, rd, f);
    mem_req = 1'b1; mem_we = we; mem_addr = a; mem_wdata = wd; mem_acc_width = w;
    k = 0;
    seen = 1'b0;
    while (!seen && k < 20) begin
      @(negedge clk);
      k++;
      if (scramble && k == 1) begin
        mem_we = 1'($urandom); mem_addr = $urandom; mem_wdata = $urandom;
        mem_acc_width = 2'($urandom);
      end
      seen = mem_ready;
    end
    if (!seen) begin
      chk({tag, "_timeout"}, 32'd0, 32'd1);
    end else begin
      last_ready_cyc = cyc;
      chk({tag, "_lat"}, k, lat);
      chk({tag, "_rdata"}, mem_rdata, rd);
      chk({tag, "_fault"}, mem_fault, f);
    end
    mem_req = 1'b0;
    @(negedge clk);
    chk({tag, "_pulse1"}, mem_ready, 1'b0);
    @(negedge clk);
  endtask

  initial begin
    int pulses;
    int first;
    int t0;
    int lat;
    logic [31:0] rd;
    logic [31:0] d;
    logic f;

    rst_n = 1'b0; mem_req = 1'b0; mem_we = 1'b0; mem_addr = '0; mem_wdata = '0;
    mem_acc_width = 2'b00;
    repeat (3) @(negedge clk);
    chk("rst_ready", mem_ready, 1'b0);
    chk("rst_rdata", mem_rdata, 32'h0);
    chk("rst_fault", mem_fault, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 64; i++) access(1'b1, 32'(i * 4), $urandom, 2'b10, 1'b0, "fill");

    access(1'b1, 32'h10, 32'hDEADBEEF, 2'b10, 1'b0, "st_w10");
    access(1'b0, 32'h10, 32'h0, 2'b10, 1'b0, "ld_w10");
    chk("ld_w10_const", mem_rdata, 32'hDEADBEEF);
    access(1'b0, 32'h12, 32'h0, 2'b00, 1'b0, "ld_b12");
    chk("ld_b12_const", mem_rdata, 32'h000000AD);
    access(1'b0, 32'h12, 32'h0, 2'b01, 1'b0, "ld_h12");
    chk("ld_h12_const", mem_rdata, 32'h0000DEAD);

    access(1'b1, 32'h000000FE, 32'h44332211, 2'b10, 1'b0, "st_wFE");
    access(1'b0, 32'hFE, 32'h0, 2'b00, 1'b0, "ld_bFE");
    access(1'b0, 32'hFF, 32'h0, 2'b00, 1'b0, "ld_bFF");
    access(1'b0, 32'h00, 32'h0, 2'b00, 1'b0, "ld_b00");
    access(1'b0, 32'h01, 32'h0, 2'b00, 1'b0, "ld_b01");
    access(1'b0, 32'hFF, 32'h0, 2'b01, 1'b0, "ld_hFF");

    access(1'b0, 32'h40, 32'h0, 2'b11, 1'b0, "rsv_ld");
    chk("rsv_rd0", mem_rdata, 32'h0);
    access(1'b1, 32'h40, 32'hFFFFFFFF, 2'b11, 1'b0, "rsv_st");
    access(1'b0, 32'h40, 32'h0, 2'b10, 1'b0, "rsv_chk");

    // Request held for 10 cycles must complete exactly once.
    model(1'b0, 32'h11, 32'h0, 2'b00, lat, rd, f);
    mem_req = 1'b1; mem_we = 1'b0; mem_addr = 32'h11; mem_acc_width = 2'b00;
    pulses = 0;
    first = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (mem_ready) begin
        if (pulses == 0) first = cyc;
        pulses++;
      end
    end
    chk("held_pulses", pulses, 1);
    chk("held_rdata", mem_rdata, rd);
    mem_req = 1'b0;
    @(negedge clk);
    @(negedge clk);
    access(1'b0, 32'h11, 32'h0, 2'b00, 1'b0, "rereq");
    chk("rereq_gap", 32'((last_ready_cyc - first) >= 4), 32'd1);
    for (int i = 0; i < 3; i++) begin
      t0 = last_ready_cyc;
      access(1'b0, 32'(i), 32'h0, 2'b00, 1'b0, "b2b");
      chk("b2b_gap", 32'((last_ready_cyc - t0) >= 4), 32'd1);
    end

    // Reset in cycle 2 of a word store: only byte 0 lands.
    d = $urandom;
    mem_req = 1'b1; mem_we = 1'b1; mem_addr = 32'h20; mem_wdata = d; mem_acc_width = 2'b10;
    pulses = 0;
    @(negedge clk);
    if (mem_ready) pulses++;
    @(negedge clk);
    if (mem_ready) pulses++;
    rst_n = 1'b0;
    mem_req = 1'b0;
    @(negedge clk);
    chk("midrst_ready", mem_ready, 1'b0);
    chk("midrst_rdata", mem_rdata, 32'h0);
    chk("midrst_fault", mem_fault, 1'b0);
    rst_n = 1'b1;
    repeat (6) begin
      @(negedge clk);
      if (mem_ready) pulses++;
    end
    chk("midrst_pulses", pulses, 0);
    ref_mem[8'h20] = d[7:0];
    last_rd = 32'h0;
    access(1'b1, 32'h21, $urandom, 2'b00, 1'b0, "fix21");
    access(1'b0, 32'h20, 32'h0, 2'b00, 1'b0, "midrst_b20");
    access(1'b0, 32'h22, 32'h0, 2'b00, 1'b0, "midrst_b22");
    access(1'b0, 32'h23, 32'h0, 2'b00, 1'b0, "midrst_b23");

    for (int i = 0; i < 80; i++)
      access(1'($urandom_range(0, 1)), $urandom, $urandom, 2'($urandom_range(0, 3)), 1'b1, "rnd");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
